// File: rtl/oai_pipe_pkg.sv
// Shared types and the per-lane OAI/AOI reduction used by oai_pipe_cell.
package oai_pipe_pkg;

  typedef enum logic {
    MODE_OAI = 1'b0,
    MODE_AOI = 1'b1
  } mode_e;

  localparam int MAX_GRP  = 8;
  localparam int MAX_GW   = 8;
  localparam int MAX_BITS = MAX_GRP * MAX_GW;

  // Bits beyond ngrp*gw are ignored, so one function serves every legal geometry.
  function automatic logic laneResult(input logic [MAX_BITS-1:0] bits,
                                      input int ngrp,
                                      input int gw,
                                      input mode_e mode);
    logic grpOr;
    logic grpAnd;
    logic allOr;
    logic anyAnd;
    allOr  = 1'b1;
    anyAnd = 1'b0;
    for (int g = 0; g < MAX_GRP; g++) begin
      if (g < ngrp) begin
        grpOr  = 1'b0;
        grpAnd = 1'b1;
        for (int i = 0; i < MAX_GW; i++) begin
          if (i < gw) begin
            grpOr  = grpOr  | bits[6'(g * gw + i)];
            grpAnd = grpAnd & bits[6'(g * gw + i)];
          end
        end
        allOr  = allOr  & grpOr;
        anyAnd = anyAnd | grpAnd;
      end
    end
    return (mode == MODE_OAI) ? ~allOr : ~anyAnd;
  endfunction

endpackage

// File: rtl/oai_pipe_stage.sv
// One pipeline slot: result, mode and valid flag, loaded whenever the slot is
// empty or its contents are leaving on this edge.
module oai_pipe_stage
  import oai_pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_ck,
  input  logic         i_rn,
  input  logic         i_inValid,
  input  logic [W-1:0] i_inData,
  input  mode_e        i_inMode,
  input  logic         i_downReady,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output mode_e        o_mode
);

  logic         r_valid;
  logic [W-1:0] r_data;
  mode_e        r_mode;
  logic         w_load;

  assign w_load = ~r_valid | i_downReady;

  always_ff @(posedge i_ck or negedge i_rn) begin
    if (!i_rn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_OAI;
    end else if (w_load) begin
      r_valid <= i_inValid;
      if (i_inValid) begin
        r_data <= i_inData;
        r_mode <= i_inMode;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;

endmodule

// File: rtl/oai_pipe_cell.sv
// Multi-lane OAI/AOI cell with a valid/ready pipeline of STAGES slots that
// collapses bubbles and can accept and emit in the same cycle.
module oai_pipe_cell
  import oai_pipe_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int NGRP   = 2,
  parameter int GW     = 2,
  parameter int STAGES = 2
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic                    IV,
  output logic                    IR,
  input  logic                    MD,
  input  logic [LANES*NGRP*GW-1:0] A,
  output logic                    OV,
  input  logic                    ORDY,
  output logic [LANES-1:0]        Y,
  output logic                    OM
);

  localparam int LANE_BITS = NGRP * GW;

  logic [LANES-1:0] w_result;
  logic [STAGES-1:0] w_valid;
  logic [STAGES:0]   w_ready;
  logic [LANES-1:0]  w_data [STAGES];
  mode_e             w_mode [STAGES];
  logic              r_live;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_result[l] = laneResult(MAX_BITS'(A[l*LANE_BITS +: LANE_BITS]),
                                    NGRP, GW, mode_e'(MD));
  end

  // A slot can take new contents if it or any slot after it is empty, or the output is draining.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = ORDY;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = w_ready[k+1] | ~w_valid[k];
    end
  end

  // Holds IR low until the first clock edge after reset is released.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  assign IR = r_live & w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         w_inValid;
    logic [LANES-1:0] w_inData;
    mode_e        w_inMode;
    if (k == 0) begin : g_first
      assign w_inValid = IV & IR;
      assign w_inData  = w_result;
      assign w_inMode  = mode_e'(MD);
    end else begin : g_next
      assign w_inValid = w_valid[k-1];
      assign w_inData  = w_data[k-1];
      assign w_inMode  = w_mode[k-1];
    end
    oai_pipe_stage #(.W(LANES)) u_stage (
      .i_ck        (CK),
      .i_rn        (RN),
      .i_inValid   (w_inValid),
      .i_inData    (w_inData),
      .i_inMode    (w_inMode),
      .i_downReady (w_ready[k+1]),
      .o_valid     (w_valid[k]),
      .o_data      (w_data[k]),
      .o_mode      (w_mode[k])
    );
  end

  assign OV = w_valid[STAGES-1];
  assign Y  = OV ? w_data[STAGES-1] : '0;
  assign OM = OV & (w_mode[STAGES-1] == MODE_AOI);

endmodule

// File: tb/tb_oai_pipe_cell.sv
// Scoreboard bench for oai_pipe_cell: default geometry plus a 1-stage 3x3 variant.
module tb_oai_pipe_cell;

  localparam int ST0 = 2;
  localparam int ST1 = 1;

  typedef struct {
    logic [7:0] y;
    logic       om;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rn;
  always #5 clk = ~clk;

  logic        iv0, ir0, md0, ov0, ordy0, om0;
  logic [15:0] a0;
  logic [3:0]  y0;
  logic        iv1, ir1, md1, ov1, ordy1, om1;
  logic [35:0] a1;
  logic [3:0]  y1;

  oai_pipe_cell dut0 (
    .CK(clk), .RN(rn), .IV(iv0), .IR(ir0), .MD(md0), .A(a0),
    .OV(ov0), .ORDY(ordy0), .Y(y0), .OM(om0)
  );

  oai_pipe_cell #(.LANES(4), .NGRP(3), .GW(3), .STAGES(1)) dut1 (
    .CK(clk), .RN(rn), .IV(iv1), .IR(ir1), .MD(md1), .A(a1),
    .OV(ov1), .ORDY(ordy1), .Y(y1), .OM(om1)
  );

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;
  int acc0 = 0, out0 = 0, acc1 = 0, out1 = 0;
  bit latChk0 = 0, latChk1 = 0;
  logic [7:0] expY0, expY1;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    nVec++;
    if (act !== req) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: OAI -> 0 only when every group has a set bit; AOI -> 0 when some group is all ones.
  function automatic logic [7:0] refModel(input logic [63:0] a, input logic md,
                                          input int lanes, input int ngrp, input int gw);
    logic [7:0]  y;
    logic [63:0] mask, grp;
    int nonZero, full;
    y = '0;
    mask = (64'd1 << gw) - 64'd1;
    for (int l = 0; l < lanes; l++) begin
      nonZero = 0;
      full = 0;
      for (int g = 0; g < ngrp; g++) begin
        grp = (a >> (l * ngrp * gw + g * gw)) & mask;
        if (grp != 0) nonZero++;
        if (grp == mask) full++;
      end
      y[l] = md ? (full == 0) : (nonZero != ngrp);
    end
    return y;
  endfunction

  always @(negedge clk) begin
    if (rn && iv0 && ir0) begin
      q0.push_back('{y: expY0, om: md0, cyc: cyc});
      acc0++;
    end
    if (rn && iv1 && ir1) begin
      q1.push_back('{y: expY1, om: md1, cyc: cyc});
      acc1++;
    end
  end

  always @(negedge clk) begin
    if (rn) begin
      if (ov0 && ordy0) begin
        if (q0.size() == 0) begin
          nVec++; nErr++;
          $display("[TB] FAIL out0_unexpected: got Y=%0h with nothing expected", y0);
        end else begin
          e0 = q0.pop_front();
          checkOutput("y0", 64'(y0), 64'(e0.y[3:0]));
          checkOutput("om0", 64'(om0), 64'(e0.om));
          if (latChk0) checkOutput("lat0", 64'(cyc - e0.cyc), 64'(ST0));
          out0++;
        end
      end
      if (!ov0) checkOutput("y0_idle", 64'(y0), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (rn) begin
      if (ov1 && ordy1) begin
        if (q1.size() == 0) begin
          nVec++; nErr++;
          $display("[TB] FAIL out1_unexpected: got Y=%0h with nothing expected", y1);
        end else begin
          e1 = q1.pop_front();
          checkOutput("y1", 64'(y1), 64'(e1.y[3:0]));
          checkOutput("om1", 64'(om1), 64'(e1.om));
          if (latChk1) checkOutput("lat1", 64'(cyc - e1.cyc), 64'(ST1));
          out1++;
        end
      end
      if (!ov1) checkOutput("y1_idle", 64'(y1), 64'd0);
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic md, input logic [7:0] y);
    iv0 = 1'b1; a0 = a; md0 = md; expY0 = y;
    @(posedge clk); #1;
  endtask

  task automatic applyRandom0(input logic md);
    logic [15:0] a;
    a = 16'($urandom);
    applyStimulus(a, md, refModel(64'(a), md, 4, 2, 2));
  endtask

  task automatic applyRandom1(input logic md);
    logic [35:0] a;
    a = {4'($urandom), 32'($urandom)};
    iv1 = 1'b1; a1 = a; md1 = md; expY1 = refModel(64'(a), md, 4, 3, 3);
    @(posedge clk); #1;
  endtask

  task automatic drain0();
    int n = 0;
    iv0 = 1'b0; ordy0 = 1'b1;
    while (q0.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    checkOutput("drain0", 64'(q0.size()), 64'd0);
  endtask

  int accStart, outStart;
  logic [3:0] yHeld;

  initial begin
    rn = 1'b0; iv0 = 0; md0 = 0; a0 = '0; ordy0 = 1; expY0 = '0;
    iv1 = 0; md1 = 0; a1 = '0; ordy1 = 1; expY1 = '0;
    #2;
    checkOutput("rst_ov0", 64'(ov0), 0); checkOutput("rst_y0", 64'(y0), 0);
    checkOutput("rst_om0", 64'(om0), 0); checkOutput("rst_ir0", 64'(ir0), 0);
    checkOutput("rst_ov1", 64'(ov1), 0); checkOutput("rst_ir1", 64'(ir1), 0);
    #10 rn = 1'b1;
    #1 checkOutput("ir0_before_edge", 64'(ir0), 0);
    @(posedge clk); #1;
    checkOutput("ir0_after_edge", 64'(ir0), 1);
    checkOutput("ir1_after_edge", 64'(ir1), 1);

    // Directed vectors, lanes 1..3 zero so they read 1 in either mode.
    latChk0 = 1;
    applyStimulus(16'h0000, 1'b0, 8'h0F);
    applyStimulus(16'h0005, 1'b0, 8'h0E);
    applyStimulus(16'h0003, 1'b0, 8'h0F);
    applyStimulus(16'h000C, 1'b1, 8'h0E);
    applyStimulus(16'h000A, 1'b1, 8'h0F);
    for (int i = 0; i < 8; i++) applyRandom0(1'(i));
    drain0();

    // Back-pressure: only two fit, output held, then simultaneous in/out.
    latChk0 = 0; ordy0 = 1'b0;
    accStart = acc0;
    for (int i = 0; i < 5; i++) applyRandom0(1'($urandom));
    checkOutput("full_accepts", 64'(acc0 - accStart), 64'(ST0));
    checkOutput("full_ir", 64'(ir0), 0);
    checkOutput("full_ov", 64'(ov0), 1);
    yHeld = y0;
    for (int i = 0; i < 2; i++) applyRandom0(1'($urandom));
    checkOutput("held_y", 64'(y0), 64'(yHeld));
    ordy0 = 1'b1;
    accStart = acc0; outStart = out0;
    #1 checkOutput("same_cycle_ir", 64'(ir0), 1);
    @(negedge clk); #1;
    checkOutput("same_cycle_in", 64'(acc0 - accStart), 1);
    checkOutput("same_cycle_out", 64'(out0 - outStart), 1);
    @(posedge clk); #1;
    drain0();

    // 100 back-to-back with ORDY held high.
    latChk0 = 1; accStart = acc0; outStart = out0;
    for (int i = 0; i < 100; i++) applyRandom0(1'($urandom));
    drain0();
    checkOutput("b2b_accepts", 64'(acc0 - accStart), 100);
    checkOutput("b2b_outputs", 64'(out0 - outStart), 100);

    // Asynchronous reset with two transactions in flight.
    latChk0 = 0; ordy0 = 1'b0;
    applyRandom0(1'b0);
    applyRandom0(1'b1);
    iv0 = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_reset_ov", 64'(ov0), 1);
    #2 rn = 1'b0;
    #1;
    checkOutput("midrst_ov", 64'(ov0), 0); checkOutput("midrst_y", 64'(y0), 0);
    checkOutput("midrst_om", 64'(om0), 0); checkOutput("midrst_ir", 64'(ir0), 0);
    q0.delete();
    repeat (2) @(posedge clk);
    #2 rn = 1'b1; ordy0 = 1'b1;
    #1 checkOutput("post_rst_ir_low", 64'(ir0), 0);
    @(posedge clk); #1;
    checkOutput("post_rst_ir_high", 64'(ir0), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checkOutput("no_stale_ov", 64'(ov0), 0);
    end

    // One-stage 3x3 variant: all-ones OAI, latency 1, then random ORDY.
    @(posedge clk); #1;
    latChk1 = 1; ordy1 = 1'b1;
    iv1 = 1'b1; a1 = {36{1'b1}}; md1 = 1'b0; expY1 = 8'h00;
    @(posedge clk); #1;
    applyRandom1(1'b1);
    applyRandom1(1'b0);
    iv1 = 1'b0;
    repeat (3) @(posedge clk); #1;
    latChk1 = 0;
    for (int i = 0; i < 200; i++) begin
      ordy1 = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) applyRandom1(1'($urandom));
      else begin iv1 = 1'b0; @(posedge clk); #1; end
    end
    iv1 = 1'b0; ordy1 = 1'b1;
    for (int n = 0; n < 20 && q1.size() != 0; n++) begin @(posedge clk); #1; end
    checkOutput("drain1", 64'(q1.size()), 0);
    checkOutput("out1_count", 64'(out1), 64'(acc1));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
